// File: rtl/seq_mult_hs_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Build option SEQ_MULT_EARLY_DONE_EN is consumed by seq_mult_hs.sv.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=2.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_mult_hs_if.sv
// Operand/result valid-ready bundle for seq_mult_hs.
interface seq_mult_hs_if #(parameter int WIDTH = 4);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, p);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, p);
endinterface

// File: rtl/seq_mult_hs_step.sv
// One radix-2 shift-and-add step, purely combinational.
module mult_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);
  assign acc_nxt    = mplier[0] ? acc + mcand : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;
endmodule

// File: rtl/seq_mult_hs.sv
// Sequential unsigned WIDTH x WIDTH multiplier with valid/ready on both sides.
// Define SEQ_MULT_EARLY_DONE_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mult_hs_if.slave  bus
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_t             state;
  logic [PW-1:0]      acc, mcand, p_q;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic               out_valid_q;

  logic [PW-1:0]      acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]   mplier_nxt;
  logic               last_step;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt)
  );

`ifdef SEQ_MULT_EARLY_DONE_EN
  // Once no multiplier bits remain, further steps cannot change acc.
  assign last_step = (mplier_nxt == '0) || (count == CNT_W'(WIDTH - 1));
`else
  assign last_step = (count == CNT_W'(WIDTH - 1));
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          count  <= count + 1'b1;
          if (last_step) begin
            p_q         <= acc_nxt;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // p_q is deliberately left alone so the last product stays readable.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
- Parametrised sequential unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product.
- Radix-2 shift-and-add, one partial product per clock. Replaces the fixed 4x4 combinational array multiplier in area-sensitive datapaths.
- Valid/ready handshake on both the operand side and the result side. The result is held until the consumer accepts it.

Parameters:
- WIDTH, 4, operand width in bits (>=2); product width is 2*WIDTH
- CNT_W, $clog2(WIDTH), step counter width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- p  output  2*WIDTH  product a*b

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: rst_n sampled low at a rising edge forces:
  - state=IDLE, in_ready=1, out_valid=0, p=0
  - internal acc/mcand/mplier/count cleared
- Reset mid-operation aborts the operation with no output. rst_n overrides all other inputs on that edge.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready at an edge:
    - mcand <= zero-extended a (2*WIDTH bits), mplier <= b, acc <= 0, count <= 0
    - next state = RUN
  - RUN: in_ready=0, out_valid=0. Each edge performs one step:
    - if mplier[0], acc <= acc + mcand (modulo 2^(2*WIDTH); no overflow is possible)
    - mcand <= mcand<<1, mplier <= mplier>>1, count <= count+1
    - When count==WIDTH-1, next state = DONE, and p <= the final acc value, including this step's addition.
  - DONE: out_valid=1, p stable, in_ready=0.
    - On out_ready at an edge: next state = IDLE, out_valid=0. p keeps its last value.
    - out_ready low: hold indefinitely (backpressure). p and out_valid must not change.
- Latency: handshake at edge k -> out_valid visible after edge k+WIDTH.
- Throughput: one product per WIDTH+2 cycles with out_ready tied high.
- in_ready is combinational from state only (==IDLE); out_valid is registered (state==DONE).
- No combinational path exists from in_valid or out_ready to any output.
- Simultaneous events:
  - in_valid while not IDLE is ignored; the operands are not captured.
  - Operands a/b are sampled only at the accepting edge; later changes have no effect.
- Boundaries:
  - a=0 or b=0 -> p=0.
  - All-ones operands -> p=(2^WIDTH-1)^2 exactly (no truncation).

Optional Feature:
- Macro: SEQ_MULT_EARLY_DONE_EN
- Defined: RUN exits to DONE on the edge where (mplier>>1)==0 or count==WIDTH-1, whichever comes first.
  - Latency equals the index of the highest set bit of b, plus 1.
  - b=0 gives latency 1.
- Not defined: latency is always exactly WIDTH cycles, independent of data.
- The product value is identical in both builds.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum/localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - function for CNT_W derivation
- One combinational sub-module, mult_step (inputs acc, mcand, mplier; outputs next acc, next mcand, next mplier), keeps the datapath separately checkable.
- Control FSM and registers stay in the top module.

Test Plan:
- WIDTH=4, a=15, b=15, out_ready=1 -> p=225; out_valid rises exactly 4 cycles after accept (early-done build: also 4).
- WIDTH=4, a=9, b=6 -> p=54.
  - Default build: latency 4.
  - SEQ_MULT_EARLY_DONE_EN: latency 3.
- WIDTH=4, a=7, b=0 -> p=0.
  - Default build: latency 4.
  - Early-done build: latency 1.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - p=54 and out_valid hold.
  - in_ready stays 0; a second in_valid pulse is ignored.
  - Raise out_ready -> IDLE next cycle.
- Reset mid-operation: drive rst_n=0 two cycles into RUN.
  - Next edge: in_ready=1, out_valid=0, p=0.
  - A new multiply 3*5 afterwards yields p=15.
- WIDTH=8, a=255, b=255 -> p=65025.
  - Random back-to-back ops (1000 vectors) match the a*b reference model with latency 8.
